// File: rtl/vsyncinfo_pkg.sv
// Shared definitions for the vsync-info RAM write-side sequencer.
// Holds the RAM geometry, the FSM state encoding and the word-packing helper.
package vsyncinfo_pkg;

  localparam int VI_RAM_AW = 5;
  localparam int VI_DATA_W = 64;
  localparam logic [VI_RAM_AW-1:0] VI_BANK_WORDS = 5'd16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    PUBLISH = 2'd3
  } vi_state_e;

  function automatic logic [VI_DATA_W-1:0] vi_pack(input logic [31:0] hi, input logic [31:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Two-flop synchroniser for the asynchronous vsync level plus a rising-edge detector.
// The pulse is one clock wide and comes purely from registers.
module vsync_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // synchroniser chain and edge-history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= async_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/vsyncinfo_wr_ctrl.sv
// Packs a 32-bit info stream into 64-bit words of a ping-pong banked RAM and publishes
// the finished bank, its word count and a toggle flag on every vsync.
module vsyncinfo_wr_ctrl
  import vsyncinfo_pkg::*;
#(
  parameter int          RAM_AW   = VI_RAM_AW,
  parameter logic [31:0] PAD_WORD = 32'h0
) (
  input  logic                 sysclk,
  input  logic                 nRST,
  input  logic                 vsync_in,
  input  logic                 info_valid,
  input  logic [31:0]          info_data,
  output logic                 info_ready,
  output logic                 ram_wren,
  output logic [RAM_AW-1:0]    ram_wraddress,
  output logic [VI_DATA_W-1:0] ram_data,
  output logic                 frame_bank,
  output logic [RAM_AW-1:0]    frame_words,
  output logic                 frame_toggle,
  output logic                 overflow_err,
  input  logic                 clear_err
);

  localparam logic [RAM_AW-1:0] BANK_WORDS = RAM_AW'(2 ** (RAM_AW - 1));
  localparam logic [RAM_AW-1:0] CNT_ONE    = RAM_AW'(1);

  vi_state_e              state_r;
  vi_state_e              state_nxt_s;
  logic                   vs_rise_s;
  logic                   info_ready_s;
  logic                   accept_s;
  logic                   drop_s;
  logic                   cur_bank_r;
  logic [RAM_AW-1:0]      cnt_r;
  logic                   pending_r;
  logic [31:0]            lo_r;
  logic                   ram_wren_r;
  logic [RAM_AW-1:0]      ram_wraddress_r;
  logic [VI_DATA_W-1:0]   ram_data_r;
  logic                   frame_bank_r;
  logic [RAM_AW-1:0]      frame_words_r;
  logic                   frame_toggle_r;
  logic                   overflow_err_r;

  vsync_edge_sync u_vsync_sync (
    .clk      (sysclk),
    .rst_n    (nRST),
    .async_in (vsync_in),
    .rise     (vs_rise_s)
  );

  // FSM state register
  always_ff @(posedge sysclk or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state and handshake decode; ready depends only on registered state
  always_comb begin
    state_nxt_s  = state_r;
    info_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (vs_rise_s) begin
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        info_ready_s = ~vs_rise_s;
        if (vs_rise_s) begin
          if (pending_r) begin
            state_nxt_s = FLUSH;
          end else begin
            state_nxt_s = PUBLISH;
          end
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      FLUSH:   state_nxt_s = PUBLISH;
      PUBLISH: state_nxt_s = COLLECT;
      default: state_nxt_s = IDLE;
    endcase
  end

  assign accept_s = info_valid & info_ready_s;
  assign drop_s   = accept_s & (cnt_r == BANK_WORDS);

  // packing, RAM write port and frame publication
  always_ff @(posedge sysclk or negedge nRST) begin
    if (!nRST) begin
      cur_bank_r      <= 1'b0;
      cnt_r           <= '0;
      pending_r       <= 1'b0;
      lo_r            <= 32'h0;
      ram_wren_r      <= 1'b0;
      ram_wraddress_r <= '0;
      ram_data_r      <= '0;
      frame_bank_r    <= 1'b0;
      frame_words_r   <= '0;
      frame_toggle_r  <= 1'b0;
    end else begin
      ram_wren_r <= 1'b0;
      if (accept_s) begin
        // a full bank always has pending clear, so drops never split a word pair
        if (drop_s) begin
          cnt_r <= cnt_r;
        end else if (pending_r) begin
          ram_wren_r      <= 1'b1;
          ram_wraddress_r <= {cur_bank_r, cnt_r[RAM_AW-2:0]};
          ram_data_r      <= vi_pack(info_data, lo_r);
          cnt_r           <= cnt_r + CNT_ONE;
          pending_r       <= 1'b0;
        end else begin
          lo_r      <= info_data;
          pending_r <= 1'b1;
        end
      end else if (state_r == FLUSH) begin
        ram_wren_r      <= 1'b1;
        ram_wraddress_r <= {cur_bank_r, cnt_r[RAM_AW-2:0]};
        ram_data_r      <= vi_pack(PAD_WORD, lo_r);
        cnt_r           <= cnt_r + CNT_ONE;
      end else if (state_r == PUBLISH) begin
        frame_bank_r   <= cur_bank_r;
        frame_words_r  <= cnt_r;
        frame_toggle_r <= ~frame_toggle_r;
        cur_bank_r     <= ~cur_bank_r;
        cnt_r          <= '0;
        pending_r      <= 1'b0;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // sticky overflow flag; a new overflow beats a same-cycle clear
  always_ff @(posedge sysclk or negedge nRST) begin
    if (!nRST) begin
      overflow_err_r <= 1'b0;
    end else if (drop_s) begin
      overflow_err_r <= 1'b1;
    end else if (clear_err) begin
      overflow_err_r <= 1'b0;
    end else begin
      overflow_err_r <= overflow_err_r;
    end
  end

  assign info_ready    = info_ready_s;
  assign ram_wren      = ram_wren_r;
  assign ram_wraddress = ram_wraddress_r;
  assign ram_data      = ram_data_r;
  assign frame_bank    = frame_bank_r;
  assign frame_words   = frame_words_r;
  assign frame_toggle  = frame_toggle_r;
  assign overflow_err  = overflow_err_r;

endmodule

// File: tb/tb_vsyncinfo_wr_ctrl.sv
// Scoreboard bench for vsyncinfo_wr_ctrl: a frame-level model queues expected RAM writes
// and publications as words are accepted; monitors pop and compare them.
module tb_vsyncinfo_wr_ctrl;

  logic        sysclk;
  logic        nRST;
  logic        vsync_in;
  logic        info_valid;
  logic [31:0] info_data;
  logic        info_ready;
  logic        ram_wren;
  logic [4:0]  ram_wraddress;
  logic [63:0] ram_data;
  logic        frame_bank;
  logic [4:0]  frame_words;
  logic        frame_toggle;
  logic        overflow_err;
  logic        clear_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [68:0] wq[$];
  logic [6:0]  pq[$];

  logic        m1, m2, m3;
  logic        mcollect;
  int          hold;
  int          mwords;
  logic [31:0] mlo;
  logic        mbank;
  logic        mtog;
  logic        mover;
  logic        ptog;

  vsyncinfo_wr_ctrl dut (
    .sysclk        (sysclk),
    .nRST          (nRST),
    .vsync_in      (vsync_in),
    .info_valid    (info_valid),
    .info_data     (info_data),
    .info_ready    (info_ready),
    .ram_wren      (ram_wren),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .frame_bank    (frame_bank),
    .frame_words   (frame_words),
    .frame_toggle  (frame_toggle),
    .overflow_err  (overflow_err),
    .clear_err     (clear_err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check_val(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // frame-level reference: sync timing, packing, banking and overflow
  initial begin
    logic r, acc, drop;
    logic [3:0] widx;
    forever begin
      @(posedge sysclk or negedge nRST);
      if (!nRST) begin
        m1 = 1'b0; m2 = 1'b0; m3 = 1'b0;
        mcollect = 1'b0; hold = 0; mwords = 0; mlo = 32'h0;
        mbank = 1'b0; mtog = 1'b0; mover = 1'b0;
      end else begin
        r    = m2 & ~m3;
        acc  = info_valid & info_ready;
        drop = 1'b0;
        check_val("ready", 69'(info_ready), 69'(mcollect && hold == 0 && !r));
        if (hold > 0) begin
          hold--;
        end else if (mcollect) begin
          if (r) begin
            widx = 4'(mwords >> 1);
            if (mwords % 2 == 1) wq.push_back({mbank, widx, 32'h0, mlo});
            pq.push_back({mbank, 5'((mwords + 1) / 2), ~mtog});
            hold   = (mwords % 2 == 1) ? 2 : 1;
            mtog   = ~mtog;
            mbank  = ~mbank;
            mwords = 0;
          end else if (acc) begin
            if (mwords >= 32) begin
              drop = 1'b1;
            end else begin
              widx = 4'(mwords >> 1);
              if (mwords % 2 == 1) wq.push_back({mbank, widx, info_data, mlo});
              else mlo = info_data;
              mwords++;
            end
          end
        end else if (r) begin
          mcollect = 1'b1;
        end
        if (drop) mover = 1'b1;
        else if (clear_err) mover = 1'b0;
        m3 = m2; m2 = m1; m1 = vsync_in;
      end
    end
  end

  // output monitor: RAM writes, publications and the sticky error flag
  initial begin
    logic [68:0] ew;
    logic [6:0]  ep;
    ptog = 1'b0;
    forever begin
      @(negedge sysclk);
      if (!nRST) begin
        ptog = 1'b0;
      end else begin
        if (ram_wren) begin
          if (wq.size() == 0) check_val("unexpected_write", {ram_wraddress, ram_data}, 69'(0));
          else begin
            ew = wq.pop_front();
            check_val("ram_write", {ram_wraddress, ram_data}, ew);
          end
        end
        if (frame_toggle !== ptog) begin
          if (pq.size() == 0) check_val("unexpected_publish", 69'({frame_bank, frame_words, frame_toggle}), 69'(0));
          else begin
            ep = pq.pop_front();
            check_val("publish", 69'({frame_bank, frame_words, frame_toggle}), 69'(ep));
          end
        end
        check_val("overflow", 69'(overflow_err), 69'(mover));
        ptog = frame_toggle;
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int t;
    t = 0;
    @(negedge sysclk);
    info_valid = 1'b1;
    info_data  = w;
    while (!info_ready && t < 200) begin
      @(negedge sysclk);
      t++;
    end
    if (!info_ready) check_val("accept_timeout", 69'(0), 69'(1));
    else @(posedge sysclk);
  endtask

  task automatic idle_bus(input int n);
    @(negedge sysclk);
    info_valid = 1'b0;
    repeat (n) @(negedge sysclk);
  endtask

  task automatic vsync_pulse;
    @(negedge sysclk);
    vsync_in = 1'b1;
    repeat (5) @(negedge sysclk);
    vsync_in = 1'b0;
    repeat (6) @(negedge sysclk);
  endtask

  task automatic check_frame(input string tag, input logic b, input logic [4:0] w, input logic t);
    check_val(tag, 69'({frame_bank, frame_words, frame_toggle}), 69'({b, w, t}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; vsync_in = 1'b0; info_valid = 1'b0; info_data = 32'h0; clear_err = 1'b0;
    repeat (3) @(negedge sysclk);
    check_val("reset_outs", 69'({info_ready, ram_wren, ram_wraddress, frame_bank, frame_words, frame_toggle, overflow_err}), 69'(0));
    check_val("reset_data", 69'(ram_data), 69'(0));
    nRST = 1'b1;
    repeat (2) @(negedge sysclk);

    // 1: four words into bank 0
    vsync_pulse();
    send_word(32'hAAAA_0001); send_word(32'hBBBB_0002);
    send_word(32'hCCCC_0003); send_word(32'hDDDD_0004);
    idle_bus(3);
    vsync_pulse();
    check_frame("t1_frame", 1'b0, 5'd2, 1'b1);

    // 2: odd count, flushed into bank 1
    send_word(32'hEEEE_0005); send_word(32'hFFFF_0006); send_word(32'h1111_0007);
    idle_bus(3);
    vsync_pulse();
    check_frame("t2_frame", 1'b1, 5'd2, 1'b0);

    // 3: overflow with 34 words
    for (int i = 0; i < 34; i++) send_word(32'h3000_0000 + 32'(i));
    idle_bus(2);
    check_val("t3_ovf_set", 69'(overflow_err), 69'(1));
    vsync_pulse();
    check_frame("t3_frame", 1'b0, 5'd16, 1'b1);
    check_val("t3_ovf_held", 69'(overflow_err), 69'(1));
    clear_err = 1'b1;
    @(negedge sysclk);
    clear_err = 1'b0;
    @(negedge sysclk);
    check_val("t3_ovf_clr", 69'(overflow_err), 69'(0));

    // 4: valid held high across a vsync edge
    fork
      begin
        for (int i = 0; i < 8; i++) send_word(32'h4000_0000 + 32'(i));
      end
      begin
        repeat (3) @(negedge sysclk);
        vsync_in = 1'b1;
        repeat (5) @(negedge sysclk);
        vsync_in = 1'b0;
      end
    join
    idle_bus(6);
    check_val("t4_bank", 69'({frame_bank, frame_toggle}), 69'({1'b1, 1'b0}));
    vsync_pulse();
    check_val("t4_next", 69'({frame_bank, frame_toggle}), 69'({1'b0, 1'b1}));

    // 5: two empty frames
    vsync_pulse();
    check_frame("t5_empty_a", 1'b1, 5'd0, 1'b0);
    vsync_pulse();
    check_frame("t5_empty_b", 1'b0, 5'd0, 1'b1);

    // 6: reset mid-frame
    send_word(32'h6000_0001); send_word(32'h6000_0002); send_word(32'h6000_0003);
    idle_bus(4);
    check_val("t6_queue", 69'(wq.size() + pq.size()), 69'(0));
    #2 nRST = 1'b0;
    #1 check_val("t6_rst_outs", 69'({info_ready, ram_wren, ram_wraddress, frame_bank, frame_words, frame_toggle, overflow_err}), 69'(0));
    repeat (2) @(negedge sysclk);
    nRST = 1'b1;
    info_valid = 1'b1;
    info_data  = 32'hDEAD_BEEF;
    repeat (5) @(negedge sysclk);
    check_val("t6_idle_rdy", 69'(info_ready), 69'(0));
    info_valid = 1'b0;
    vsync_pulse();
    send_word(32'h7000_0001);
    idle_bus(2);
    vsync_pulse();
    check_frame("t6_frame", 1'b0, 5'd1, 1'b1);

    repeat (4) @(negedge sysclk);
    check_val("wq_empty", 69'(wq.size()), 69'(0));
    check_val("pq_empty", 69'(pq.size()), 69'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
